// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state and requester encodings for the dmem arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_OPEN  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arb_rsp.sv
// rtl/dmem_arb_rsp.sv - per-requester read response register, one-cycle latency
module dmem_arb_rsp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= capture;
      if (capture) rdata_q <= mem_rdata;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin dmem arbiter with lock support
// Optional stall counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_wen,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_wen,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]           stall0_cnt,
  output logic [31:0]           stall1_cnt
`endif
);

  arb_state_e state_q;
  logic       prio_q;
  logic       gnt0, gnt1, any_gnt, acc_lock, gnt_idx;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      ARB_LOCK0: gnt0 = m0_valid;
      ARB_LOCK1: gnt1 = m1_valid;
      default: begin
        if (m0_valid && m1_valid) begin
          gnt0 = (prio_q == REQ_CORE);
          gnt1 = (prio_q == REQ_DBG);
        end else begin
          gnt0 = m0_valid;
          gnt1 = m1_valid;
        end
      end
    endcase
  end

  assign any_gnt  = gnt0 | gnt1;
  assign gnt_idx  = gnt1 ? REQ_DBG : REQ_CORE;
  assign acc_lock = gnt1 ? m1_lock : m0_lock;

  assign m0_ready  = gnt0;
  assign m1_ready  = gnt1;
  assign mem_wen   = gnt1 ? m1_wen : (gnt0 & m0_wen);
  assign mem_addr  = gnt1 ? m1_addr : m0_addr;
  assign mem_wdata = gnt1 ? m1_wdata : m0_wdata;

  // Pointer always lands on the requester that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_OPEN;
      prio_q  <= REQ_CORE;
    end else if (any_gnt) begin
      case (state_q)
        ARB_OPEN: begin
          prio_q <= ~gnt_idx;
          if (acc_lock) state_q <= gnt1 ? ARB_LOCK1 : ARB_LOCK0;
        end
        default: begin
          if (!acc_lock) begin
            state_q <= ARB_OPEN;
            prio_q  <= ~gnt_idx;
          end
        end
      endcase
    end
  end

  dmem_arb_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (gnt0 & ~m0_wen),
    .mem_rdata (mem_rdata),
    .rsp_valid (m0_rsp_valid),
    .rsp_rdata (m0_rsp_rdata)
  );

  dmem_arb_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (gnt1 & ~m1_wen),
    .mem_rdata (mem_rdata),
    .rsp_valid (m1_rsp_valid),
    .rsp_rdata (m1_rsp_rdata)
  );

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall0_q, stall0_d, stall1_q, stall1_d;

  always_comb begin
    stall0_d = stall0_q;
    stall1_d = stall1_q;
    if (m0_valid && !gnt0 && stall0_q != 32'hFFFF_FFFF) stall0_d = stall0_q + 32'd1;
    if (m1_valid && !gnt1 && stall1_q != 32'hFFFF_FFFF) stall1_d = stall1_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      stall0_q <= stall0_d;
      stall1_q <= stall1_d;
    end
  end

  assign stall0_cnt = stall0_q;
  assign stall1_cnt = stall1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_valid = 1'b0, m0_wen = 1'b0, m0_lock = 1'b0;
  logic [15:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m1_valid = 1'b0, m1_wen = 1'b0, m1_lock = 1'b0;
  logic [15:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic        m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall0_cnt, stall1_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp_stall0 = 0, exp_stall1 = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wen(m0_wen), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wen(m1_wen), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stall0_cnt(stall0_cnt), .stall1_cnt(stall1_cnt)
`endif
  );

  // Behavioural dmem: async read, write commits on the clock edge.
  logic [31:0] dmem [0:255];
  assign mem_rdata = dmem[mem_addr[9:2]];
  always @(posedge clk) if (mem_wen) dmem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v0, w0, l0, input logic [15:0] a0, input logic [31:0] d0,
                      input logic v1, w1, l1, input logic [15:0] a1, input logic [31:0] d1,
                      input logic er0, er1, input logic [31:0] ed0, ed1);
    m0_valid = v0; m0_wen = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_valid = v1; m1_wen = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    if (er0 && v0 && !w0) q0.push_back(ed0);
    if (er1 && v1 && !w1) q1.push_back(ed1);
    if (v0 && !er0) exp_stall0++;
    if (v1 && !er1) exp_stall1++;
    @(negedge clk);
    chk("m0_ready", {31'd0, m0_ready}, {31'd0, er0});
    chk("m1_ready", {31'd0, m1_ready}, {31'd0, er1});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0;
    #1;
    chk("m0_rsp_valid_rst", {31'd0, m0_rsp_valid}, 32'd0);
    chk("m0_rsp_rdata_rst", m0_rsp_rdata, 32'd0);
    chk("m1_rsp_valid_rst", {31'd0, m1_rsp_valid}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_stall0 = 0;
    exp_stall1 = 0;
`ifdef DMEM_ARB_STATS_EN
    chk("stall0_cnt_rst", stall0_cnt, 32'd0);
    chk("stall1_cnt_rst", stall1_cnt, 32'd0);
`endif
  endtask

  logic [31:0] last0, last1;
  initial begin
    last0 = '0;
    last1 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last0 = '0;
        last1 = '0;
      end else begin
        if (m0_rsp_valid) begin
          if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL m0_rsp_unexpected: got valid with %h expected none at %0t", m0_rsp_rdata, $time);
          end else begin
            last0 = q0.pop_front();
            chk("m0_rsp_rdata", m0_rsp_rdata, last0);
          end
        end else chk("m0_rsp_hold", m0_rsp_rdata, last0);
        if (m1_rsp_valid) begin
          if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL m1_rsp_unexpected: got valid with %h expected none at %0t", m1_rsp_rdata, $time);
          end else begin
            last1 = q1.pop_front();
            chk("m1_rsp_rdata", m1_rsp_rdata, last1);
          end
        end else chk("m1_rsp_hold", m1_rsp_rdata, last1);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset();
    // single-requester write then read-after-write
    step(1,1,0,16'h0010,32'hDEADBEEF, 0,0,0,16'h0000,32'h0, 1,0, 32'h0,32'h0);
    step(1,0,0,16'h0010,32'h0,        0,0,0,16'h0000,32'h0, 1,0, 32'hDEADBEEF,32'h0);
    step(0,0,0,16'h0000,32'h0,        1,1,0,16'h0020,32'h11112222, 0,1, 32'h0,32'h0);
    step(1,1,0,16'h0024,32'hA5A50F0F, 0,0,0,16'h0000,32'h0, 1,0, 32'h0,32'h0);
    step(0,0,0,16'h0000,32'h0,        1,1,0,16'h0028,32'h0BADF00D, 0,1, 32'h0,32'h0);
    // both valid: alternate m0, m1, m0, m1
    step(1,0,0,16'h0010,32'h0, 1,0,0,16'h0020,32'h0, 1,0, 32'hDEADBEEF,32'h0);
    step(1,0,0,16'h0024,32'h0, 1,0,0,16'h0020,32'h0, 0,1, 32'h0,32'h11112222);
    step(1,0,0,16'h0024,32'h0, 1,0,0,16'h0028,32'h0, 1,0, 32'hA5A50F0F,32'h0);
    step(1,0,0,16'h0010,32'h0, 1,0,0,16'h0028,32'h0, 0,1, 32'h0,32'h0BADF00D);
    step(1,0,0,16'h0010,32'h0, 0,0,0,16'h0000,32'h0, 1,0, 32'hDEADBEEF,32'h0);
    // m1 locked read-modify-write while m0 waits
    step(1,0,0,16'h0024,32'h0, 1,0,1,16'h0020,32'h0,        0,1, 32'h0,32'h11112222);
    step(1,0,0,16'h0024,32'h0, 1,1,0,16'h0020,32'h33334444, 0,1, 32'h0,32'h0);
    step(1,0,0,16'h0024,32'h0, 1,0,0,16'h0020,32'h0,        1,0, 32'hA5A50F0F,32'h0);
    step(0,0,0,16'h0000,32'h0, 1,0,0,16'h0020,32'h0,        0,1, 32'h0,32'h33334444);
    // m0 locks, idles three cycles, then unlocks
    step(1,0,1,16'h0010,32'h0,        1,0,0,16'h0028,32'h0, 1,0, 32'hDEADBEEF,32'h0);
    step(0,0,0,16'h0000,32'h0,        1,0,0,16'h0028,32'h0, 0,0, 32'h0,32'h0);
    step(0,0,0,16'h0000,32'h0,        1,0,0,16'h0028,32'h0, 0,0, 32'h0,32'h0);
    step(0,0,0,16'h0000,32'h0,        1,0,0,16'h0028,32'h0, 0,0, 32'h0,32'h0);
    step(1,1,0,16'h002C,32'h5A5A1234, 1,0,0,16'h0028,32'h0, 1,0, 32'h0,32'h0);
    step(1,0,0,16'h002C,32'h0,        1,0,0,16'h0028,32'h0, 0,1, 32'h0,32'h0BADF00D);
    step(1,0,0,16'h002C,32'h0,        0,0,0,16'h0000,32'h0, 1,0, 32'h5A5A1234,32'h0);
`ifdef DMEM_ARB_STATS_EN
    chk("stall0_cnt", stall0_cnt, exp_stall0);
    chk("stall1_cnt", stall1_cnt, exp_stall1);
`endif
    // reset drops an in-flight read and returns the pointer to m0
    step(1,0,0,16'h0010,32'h0, 0,0,0,16'h0000,32'h0, 1,0, 32'hDEADBEEF,32'h0);
    void'(q0.pop_back());
    do_reset();
    step(1,0,0,16'h0024,32'h0, 1,0,0,16'h0028,32'h0, 1,0, 32'hA5A50F0F,32'h0);
    step(0,0,0,16'h0000,32'h0, 1,0,0,16'h0028,32'h0, 0,1, 32'h0,32'h0BADF00D);
    // reset out of a lock returns to OPEN
    step(1,0,1,16'h002C,32'h0, 0,0,0,16'h0000,32'h0, 1,0, 32'h5A5A1234,32'h0);
    void'(q0.pop_back());
    do_reset();
    step(0,0,0,16'h0000,32'h0, 1,0,0,16'h0020,32'h0, 0,1, 32'h0,32'h33334444);
    step(0,0,0,16'h0000,32'h0, 0,0,0,16'h0000,32'h0, 0,0, 32'h0,32'h0);
    @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter that shares the single data memory (async read, sync write) between requester 0 (core load/store unit) and requester 1 (debug/DMA port).
- Issues at most one memory access per cycle and returns registered read data one cycle after acceptance.
- Supports a lock for atomic multi-access sequences.
- Sits between the core/debug masters and the dmem instance.

Parameters:
- ADDR_WIDTH, 16, byte address width, matches dmem.
- DATA_WIDTH, 32, data word width, matches dmem.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- m0_valid  in  1  requester 0 request valid.
- m0_ready  out  1  requester 0 request accepted this cycle.
- m0_wen  in  1  1 = write, 0 = read.
- m0_lock  in  1  hold grant after this access.
- m0_addr  in  ADDR_WIDTH  byte address.
- m0_wdata  in  DATA_WIDTH  write data.
- m0_rsp_valid  out  1  read data valid.
- m0_rsp_rdata  out  DATA_WIDTH  read data.
- m1_valid, m1_ready, m1_wen, m1_lock, m1_addr, m1_wdata, m1_rsp_valid, m1_rsp_rdata: same as m0, for requester 1.
- mem_wen  out  1  to dmem wen.
- mem_addr  out  ADDR_WIDTH  to dmem addr.
- mem_wdata  out  DATA_WIDTH  to dmem wdata.
- mem_rdata  in  DATA_WIDTH  from dmem rdata (async).

Behaviour:
- Reset values: state = OPEN, prio pointer = 0 (m0 preferred). All rsp_valid = 0, all rsp_rdata = 0.
- States and grant rules:
  - OPEN: grant goes to the valid requester. If both are valid, grant goes to the prio pointer's requester.
  - LOCK0 / LOCK1: grant goes only to the locked requester. The other requester's ready = 0.
- Grant path is combinational: mX_ready = grant to X (the granted requester's valid is asserted).
  - mem_addr, mem_wdata are muxed from the granted requester.
  - mem_wen = granted valid & granted wen.
  - No grant: mem_wen = 0; mem_addr/mem_wdata hold requester 0 values (don't care).
- Accepted access = valid & ready.
  - Write commits at that posedge, through dmem.
  - Read: mem_rdata is captured into mX_rsp_rdata at that posedge, and mX_rsp_valid = 1 for exactly the next cycle. Latency is 1.
  - Write: no response; rsp_valid stays 0.
- rsp_rdata holds its last value when rsp_valid = 0.
- Prio pointer: after every accepted access in OPEN, the pointer moves to the other requester. It is unchanged in LOCK states.
- Transitions:
  - OPEN -> LOCKx on an accepted access with mx_lock = 1.
  - LOCKx -> OPEN on an accepted access with mx_lock = 0. The pointer then flips to the other requester.
  - LOCKx with mx_valid = 0: stay locked; other requester stalls.
- Back-to-back: one access per cycle. No bubble between requesters.
- Read-after-write to the same address on consecutive cycles returns the new data, since the dmem write is already committed.
- Reset mid-operation: state, pointer and rsp_valid clear asynchronously. An in-flight response is dropped.
- Requesters hold valid and payload stable until ready. The arbiter does not check this.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Adds outputs stall0_cnt and stall1_cnt, 32 bits each.
  - Each counter increments on every cycle where mX_valid = 1 and mX_ready = 0.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: no counter ports or logic. Port list is as above.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding constants ARB_OPEN = 2'd0, ARB_LOCK0 = 2'd1, ARB_LOCK1 = 2'd2;
  - requester index constants REQ_CORE = 0, REQ_DBG = 1.
- Natural sub-module: dmem_arb_rsp. It is the per-requester response register (rsp_valid, rsp_rdata capture), instantiated twice.

Test Plan:
- Reset, then m0 write 0xDEADBEEF to 0x0010 and m0 read 0x0010 next cycle -> m0_ready = 1 both cycles; m0_rsp_valid = 1 one cycle after the read; m0_rsp_rdata = 0xDEADBEEF.
- Both valid every cycle for 4 cycles, both reading -> grants m0, m1, m0, m1; each rsp_valid asserts only on its own requester, one cycle after its grant.
- m1 reads 0x0020 with lock = 1, then writes 0x0020 with lock = 0, while m0 is valid throughout -> m0_ready = 0 for both cycles; m0 is granted on the third cycle.
- m0 locks, then drops valid for 3 cycles while m1 is valid -> m1_ready stays 0 and state stays LOCK0; m0's unlocking access then releases, and m1 is granted next.
- Assert rst_n = 0 in the cycle after an accepted m0 read -> m0_rsp_valid = 0 immediately; state OPEN; pointer back to m0.
- With DMEM_ARB_STATS_EN: m1 blocked 5 cycles by m0's lock -> stall1_cnt = 5 and stall0_cnt = 0.
